dmem_arbiter: RTL and testbench

//  Sequences and shares the single-port data memory between two requesters: the CPU memory stage (cpu_*) and a debug/loader port (dbg_*).

---
 rtl/dmem_arbiter_pkg.sv | 12 +
 rtl/dmem_arbiter_rr_arb2.sv | 18 +
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: FSM state codes, memory depth, port indices.
package dmem_arbiter_pkg;
  localparam int DMEM_DATA_WID = 32;
  localparam int DMEM_LAST     = 100;

  localparam logic [1:0] DMEM_ST_IDLE  = 2'd0;
  localparam logic [1:0] DMEM_ST_ISSUE = 2'd1;
  localparam logic [1:0] DMEM_ST_RESP  = 2'd2;

  localparam int DMEM_PORT_CPU = 0;
  localparam int DMEM_PORT_DBG = 1;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker, purely combinational; i_ptr names the port favoured on a tie.
// o_next_ptr points away from whichever port was granted and holds when nothing is granted.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt,
  output logic       o_next_ptr
);
  always_comb begin
    o_gnt = i_req;
    if (&i_req) o_gnt = i_ptr ? 2'b10 : 2'b01;
    o_next_ptr = i_ptr;
    if (o_gnt[DMEM_PORT_CPU])      o_next_ptr = 1'b1;
    else if (o_gnt[DMEM_PORT_DBG]) o_next_ptr = 1'b0;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares a combinational single-port data memory between CPU and debug ports: req -> gnt +1 -> done +2.
// One access per 3 cycles; requests are only sampled in IDLE, so a loser simply holds req until served.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WID = DMEM_DATA_WID,
  parameter int MEM_LAST = DMEM_LAST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [DATA_WID-1:0] cpu_addr,
  input  logic [DATA_WID-1:0] cpu_wdata,
  output logic                cpu_gnt,
  output logic                cpu_done,
  output logic [DATA_WID-1:0] cpu_rdata,
  output logic                cpu_err,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [DATA_WID-1:0] dbg_addr,
  input  logic [DATA_WID-1:0] dbg_wdata,
  output logic                dbg_gnt,
  output logic                dbg_done,
  output logic [DATA_WID-1:0] dbg_rdata,
  output logic                dbg_err,
  output logic [DATA_WID-1:0] mem_addr,
  output logic [DATA_WID-1:0] mem_wdata,
  output logic                mem_write_flag,
  output logic                mem_read_flag,
  input  logic [DATA_WID-1:0] mem_valM,
  input  logic                mem_error,
  output logic                busy
);
  logic [1:0]          r_state;
  logic                r_ptr;
  logic                r_owner;
  logic                r_we;
  logic                r_range_err;
  logic [1:0]          w_gnt;
  logic                w_next_ptr;
  logic                w_sel_we;
  logic [DATA_WID-1:0] w_sel_addr;
  logic [DATA_WID-1:0] w_sel_wdata;
  logic                w_sel_range;
  logic                w_err;

  rr_arb2 u_arb (
    .i_req      ({dbg_req, cpu_req}),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_next_ptr (w_next_ptr)
  );

  assign w_sel_we    = w_gnt[DMEM_PORT_DBG] ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_gnt[DMEM_PORT_DBG] ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_gnt[DMEM_PORT_DBG] ? dbg_wdata : cpu_wdata;
  assign w_sel_range = w_sel_addr > DATA_WID'(MEM_LAST);
  assign w_err       = r_range_err | mem_error;
  assign busy        = (r_state != DMEM_ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= DMEM_ST_IDLE;
      r_ptr          <= 1'b0;
      r_owner        <= 1'b0;
      r_we           <= 1'b0;
      r_range_err    <= 1'b0;
      cpu_gnt        <= 1'b0;
      cpu_done       <= 1'b0;
      cpu_rdata      <= '0;
      cpu_err        <= 1'b0;
      dbg_gnt        <= 1'b0;
      dbg_done       <= 1'b0;
      dbg_rdata      <= '0;
      dbg_err        <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_write_flag <= 1'b0;
      mem_read_flag  <= 1'b0;
    end else begin
      cpu_gnt        <= 1'b0;
      dbg_gnt        <= 1'b0;
      cpu_done       <= 1'b0;
      dbg_done       <= 1'b0;
      mem_write_flag <= 1'b0;
      mem_read_flag  <= 1'b0;
      case (r_state)
        DMEM_ST_IDLE: begin
          if (|w_gnt) begin
            r_owner        <= w_gnt[DMEM_PORT_DBG];
            r_ptr          <= w_next_ptr;
            r_we           <= w_sel_we;
            r_range_err    <= w_sel_range;
            // Address/data only move here, so they are stable whenever a flag is high and after it falls.
            mem_addr       <= w_sel_addr;
            mem_wdata      <= w_sel_wdata;
            mem_read_flag  <= !w_sel_we && !w_sel_range;
            mem_write_flag <= w_sel_we && !w_sel_range;
            cpu_gnt        <= w_gnt[DMEM_PORT_CPU];
            dbg_gnt        <= w_gnt[DMEM_PORT_DBG];
            r_state        <= DMEM_ST_ISSUE;
          end
        end
        DMEM_ST_ISSUE: begin
          if (r_owner) begin
            dbg_done <= 1'b1;
            dbg_err  <= w_err;
            if (!r_we && !w_err) dbg_rdata <= mem_valM;
          end else begin
            cpu_done <= 1'b1;
            cpu_err  <= w_err;
            if (!r_we && !w_err) cpu_rdata <= mem_valM;
          end
          r_state <= DMEM_ST_RESP;
        end
        default: r_state <= DMEM_ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural combinational memory (depth 101 words).
module tb_dmem_arbiter;
  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic        cpu_gnt, cpu_done, cpu_err, dbg_gnt, dbg_done, dbg_err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_valM;
  logic        mem_write_flag, mem_read_flag, mem_error, busy;
  logic        tb_mem_err;
  logic [31:0] mem [0:100];
  int          n_chk;
  int          n_fail;
  logic [31:0] prev_addr;
  logic        prev_flag;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write_flag(mem_write_flag),
    .mem_read_flag(mem_read_flag), .mem_valM(mem_valM), .mem_error(mem_error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_write_flag && mem_addr <= 32'd100) mem[mem_addr[6:0]] <= mem_wdata;
  assign mem_valM  = (mem_read_flag && mem_addr <= 32'd100) ? mem[mem_addr[6:0]] : 32'd0;
  assign mem_error = tb_mem_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags mutually exclusive; address frozen while a flag is high and one cycle after.
  always @(negedge clk) begin
    if (rst) begin
      prev_flag = 1'b0;
    end else begin
      chk("flags_excl", 32'(mem_read_flag & mem_write_flag), 32'd0);
      if (prev_flag) chk("addr_stable", mem_addr, prev_addr);
      prev_flag = mem_read_flag | mem_write_flag;
      prev_addr = mem_addr;
    end
  end

  // Issued from an IDLE cycle; checks gnt at +1, done/rdata/err at +2, idle at +3.
  task automatic acc(input logic port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err, input logic drop);
    logic ok;
    ok = (addr <= 32'd100);
    if (port) begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    tick();
    chk("gnt",   32'(port ? dbg_gnt : cpu_gnt), 32'd1);
    chk("gnt_other", 32'(port ? cpu_gnt : dbg_gnt), 32'd0);
    chk("done_early", 32'(port ? dbg_done : cpu_done), 32'd0);
    chk("rflag", 32'(mem_read_flag),  32'(!we && ok));
    chk("wflag", 32'(mem_write_flag), 32'(we && ok));
    if (drop) begin cpu_req = 1'b0; dbg_req = 1'b0; end
    tick();
    chk("done",  32'(port ? dbg_done : cpu_done), 32'd1);
    chk("rdata", port ? dbg_rdata : cpu_rdata, exp_rd);
    chk("err",   32'(port ? dbg_err : cpu_err), 32'(exp_err));
    chk("resp_flags", 32'({mem_read_flag, mem_write_flag}), 32'd0);
    cpu_req = 1'b0; dbg_req = 1'b0;
    tick();
    chk("idle", 32'({busy, cpu_done, dbg_done}), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    prev_flag = 1'b0; prev_addr = '0; tb_mem_err = 1'b0;
    for (int i = 0; i <= 100; i++) mem[i] = 32'd0;
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    #2;
    chk("rst_ctl", 32'({busy, cpu_gnt, cpu_done, cpu_err, dbg_gnt, dbg_done, dbg_err,
                        mem_read_flag, mem_write_flag}), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    tick();
    rst = 1'b0;

    // CPU write then read-back
    acc(1'b0, 1'b1, 32'd5, 32'hDEAD, 32'd0, 1'b0, 1'b0);
    acc(1'b0, 1'b0, 32'd5, 32'd0, 32'hDEAD, 1'b0, 1'b0);

    // Simultaneous requests after reset: CPU first, then strict alternation
    do_reset();
    cpu_we = 1'b0; cpu_addr = 32'd5; dbg_we = 1'b0; dbg_addr = 32'd5;
    cpu_req = 1'b1; dbg_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt_cpu_gnt", 32'(cpu_gnt), 32'((k % 2) == 0));
      chk("alt_dbg_gnt", 32'(dbg_gnt), 32'((k % 2) == 1));
      tick();
      tick();
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("alt_cpu_rdata", cpu_rdata, 32'hDEAD);
    chk("alt_dbg_rdata", dbg_rdata, 32'hDEAD);

    // Out-of-range debug accesses, then a good one clears err
    acc(1'b1, 1'b1, 32'd101, 32'h1, 32'hDEAD, 1'b1, 1'b0);
    acc(1'b1, 1'b0, 32'd101, 32'd0, 32'hDEAD, 1'b1, 1'b0);
    acc(1'b1, 1'b1, 32'd9, 32'h1234, 32'hDEAD, 1'b0, 1'b0);
    acc(1'b1, 1'b0, 32'd9, 32'd0, 32'h1234, 1'b0, 1'b0);

    // Memory-reported error on a read: err set, rdata held
    tb_mem_err = 1'b1;
    acc(1'b0, 1'b0, 32'd9, 32'd0, 32'hDEAD, 1'b1, 1'b0);
    tb_mem_err = 1'b0;

    // Reset during ISSUE of a read
    acc(1'b0, 1'b1, 32'd7, 32'h77, 32'hDEAD, 1'b0, 1'b0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd7;
    tick();
    chk("mid_rflag_before", 32'(mem_read_flag), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_flags", 32'({mem_read_flag, mem_write_flag}), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_gnt", 32'(cpu_gnt), 32'd0);
    cpu_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_done", 32'({cpu_done, dbg_done, busy}), 32'd0);
    acc(1'b0, 1'b0, 32'd7, 32'd0, 32'h77, 1'b0, 1'b0);

    // Request dropped during ISSUE still completes
    acc(1'b0, 1'b1, 32'd3, 32'h55, 32'h77, 1'b0, 1'b1);
    acc(1'b0, 1'b0, 32'd3, 32'd0, 32'h55, 1'b0, 1'b0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
